// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: IEEE 1149.1 state encodings, fixed opcodes and the
// instruction-to-data-register decode used by every TAP top.
package jtag_pkg;

    typedef int unsigned uint_t;

    localparam int unsigned SHIFT_CNT_W = 16;

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_t;

    function automatic uint_t idcode_op();
        return 32'd1;
    endfunction

    function automatic uint_t bypass_op(input uint_t ir_w);
        return (32'd1 << ir_w) - 32'd1;
    endfunction

    // IDCODE and BYPASS take precedence over an overlapping USER opcode window
    function automatic dr_sel_t dr_decode(input uint_t op, input uint_t ir_w,
                                          input uint_t base, input uint_t n_user);
        if (op == idcode_op())               return DR_IDCODE;
        if (op == bypass_op(ir_w))           return DR_BYPASS;
        if (op >= base && op < base + n_user) return DR_USER;
        return DR_BYPASS;
    endfunction

endpackage

// File: rtl/jtag_tap_multi_dr_if.sv
// Pin- and core-side signal bundle of the multi-DR TAP. len_err exists only
// when JTAG_DR_LEN_CHECK_EN is defined.
interface jtag_tap_multi_dr_if #(
    parameter int unsigned IR_WIDTH      = 4,
    parameter int unsigned NUM_USER_DR   = 2,
    parameter int unsigned USER_DR_WIDTH = 16
);
    logic                                  tms;
    logic                                  tdi;
    logic                                  tdo;
    logic                                  tdo_en;
    logic [3:0]                            tap_state;
    logic [IR_WIDTH-1:0]                   instruction;
    logic [NUM_USER_DR*USER_DR_WIDTH-1:0]  user_capture_data;
    logic [NUM_USER_DR*USER_DR_WIDTH-1:0]  user_update_data;
    logic [NUM_USER_DR-1:0]                user_update_strobe;
`ifdef JTAG_DR_LEN_CHECK_EN
    logic                                  len_err;
`endif

    modport master (
        output tms, tdi, user_capture_data,
`ifdef JTAG_DR_LEN_CHECK_EN
        input  len_err,
`endif
        input  tdo, tdo_en, tap_state, instruction, user_update_data, user_update_strobe
    );

    modport slave (
        input  tms, tdi, user_capture_data,
`ifdef JTAG_DR_LEN_CHECK_EN
        output len_err,
`endif
        output tdo, tdo_en, tap_state, instruction, user_update_data, user_update_strobe
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller with per-state capture/shift/update
// strobes; each strobe marks the tck edge on which that action takes effect.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state,
    output logic       tlr,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);
    tap_state_t state_q, state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state      = state_q;
    assign tlr        = (state_q == TLR);
    assign capture_dr = (state_q == CAP_DR);
    assign shift_dr   = (state_q == SH_DR);
    assign update_dr  = (state_q == UPD_DR);
    assign capture_ir = (state_q == CAP_IR);
    assign shift_ir   = (state_q == SH_IR);
    assign update_ir  = (state_q == UPD_IR);
endmodule

// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP with IDCODE, BYPASS and a bank of USERk DRs exposing parallel
// capture/update ports. Define JTAG_DR_LEN_CHECK_EN to reject wrong-length USER scans.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH         = 4,
    parameter int unsigned NUM_USER_DR      = 2,
    parameter int unsigned USER_DR_WIDTH    = 16,
    parameter logic [31:0] DEVICE_ID        = 32'h1234_5678,
    parameter int unsigned USER_BASE_OPCODE = 4
) (
    input  logic               tck,
    input  logic               trst_n,
    jtag_tap_multi_dr_if.slave bus
);
    localparam logic [IR_WIDTH-1:0] IDCODE = IR_WIDTH'(idcode_op());
    localparam int unsigned         UW     = USER_DR_WIDTH;

    tap_state_t state;
    logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    jtag_tap_fsm u_fsm (
        .tck(tck), .trst_n(trst_n), .tms(bus.tms), .state(state), .tlr(tlr),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir)
    );

    logic [IR_WIDTH-1:0]    ir_sr_q, ir_sr_d, instr_q, instr_d;
    logic [31:0]            id_sr_q, id_sr_d;
    logic                   byp_q, byp_d;
    logic [UW-1:0]          usr_sr_q, usr_sr_d, cap_val;
    logic [NUM_USER_DR-1:0] user_hit;
    logic                   upd_go, len_ok;
    dr_sel_t                dr_sel;

    assign dr_sel = dr_decode(uint_t'(instr_q), IR_WIDTH, USER_BASE_OPCODE, NUM_USER_DR);

    always_comb begin
        cap_val = '0;
        for (int k = 0; k < int'(NUM_USER_DR); k++)
            if (user_hit[k]) cap_val = bus.user_capture_data[k*UW +: UW];
    end

    // Every DR shifts in SH_DR; only the selected one is routed to tdo or updated.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        instr_d  = instr_q;
        id_sr_d  = id_sr_q;
        byp_d    = byp_q;
        usr_sr_d = usr_sr_q;
        upd_go   = 1'b0;
        if (tlr) begin
            ir_sr_d = '0;
            instr_d = IDCODE;
            id_sr_d = DEVICE_ID;
            byp_d   = 1'b0;
        end else begin
            if (capture_ir) ir_sr_d = IR_WIDTH'(2'b01);
            if (shift_ir)   ir_sr_d = {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
            if (update_ir)  instr_d = ir_sr_q;
            if (capture_dr) begin
                id_sr_d  = DEVICE_ID;
                byp_d    = 1'b0;
                usr_sr_d = cap_val;
            end
            if (shift_dr) begin
                id_sr_d  = {bus.tdi, id_sr_q[31:1]};
                byp_d    = bus.tdi;
                usr_sr_d = {bus.tdi, usr_sr_q[UW-1:1]};
            end
            if (update_dr) upd_go = (dr_sel == DR_USER) && len_ok;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sr_q  <= '0;
            instr_q  <= IDCODE;
            id_sr_q  <= DEVICE_ID;
            byp_q    <= 1'b0;
            usr_sr_q <= '0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            instr_q  <= instr_d;
            id_sr_q  <= id_sr_d;
            byp_q    <= byp_d;
            usr_sr_q <= usr_sr_d;
        end
    end

`ifdef JTAG_DR_LEN_CHECK_EN
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic                   len_err_q, len_err_d;

    assign len_ok = (cnt_q == SHIFT_CNT_W'(UW));

    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        if (tlr) begin
            cnt_d     = '0;
            len_err_d = 1'b0;
        end else if (capture_dr) begin
            cnt_d = '0;
        end else if (shift_dr) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (update_dr && dr_sel == DR_USER && !len_ok) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.len_err = len_err_q;
`else
    assign len_ok = 1'b1;
`endif

    logic [NUM_USER_DR-1:0][UW-1:0] upd_data;
    logic [NUM_USER_DR-1:0]         upd_stb;

    for (genvar k = 0; k < NUM_USER_DR; k++) begin : g_udr
        logic [UW-1:0] data_q, data_d;
        logic          stb_q, stb_d;

        assign user_hit[k] = (dr_sel == DR_USER) &&
                             (instr_q == IR_WIDTH'(USER_BASE_OPCODE + k));

        // Strobe self-clears on the next edge, giving a single-cycle pulse.
        always_comb begin
            data_d = data_q;
            stb_d  = 1'b0;
            if (upd_go && user_hit[k]) begin
                data_d = usr_sr_q;
                stb_d  = 1'b1;
            end
        end

        always_ff @(posedge tck or negedge trst_n) begin
            if (!trst_n) begin
                data_q <= '0;
                stb_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                stb_q  <= stb_d;
            end
        end

        assign upd_data[k] = data_q;
        assign upd_stb[k]  = stb_q;
    end

    always_comb begin
        bus.tdo = 1'b0;
        if (shift_ir) begin
            bus.tdo = ir_sr_q[0];
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE: bus.tdo = id_sr_q[0];
                DR_USER:   bus.tdo = usr_sr_q[0];
                default:   bus.tdo = byp_q;
            endcase
        end
    end

    assign bus.tdo_en             = shift_dr | shift_ir;
    assign bus.tap_state          = state;
    assign bus.instruction        = instr_q;
    assign bus.user_update_data   = upd_data;
    assign bus.user_update_strobe = upd_stb;
endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Scoreboard bench for jtag_tap_multi_dr: a bit-queue model of each scan pushes
// expected tdo bits and update events; a negedge monitor pops and compares.
module tb_jtag_tap_multi_dr;
    localparam int IRW  = 4;
    localparam int NUSR = 2;
    localparam int UW   = 16;
    localparam logic [31:0] DEVID = 32'h1234_5678;
    localparam int BASE = 4;

    typedef struct {
        int                     idx;
        logic [NUSR*UW-1:0]     data;
    } upd_t;

    logic tck = 1'b0;
    logic trst_n = 1'b0;
    always #5 tck = ~tck;

    jtag_tap_multi_dr_if #(.IR_WIDTH(IRW), .NUM_USER_DR(NUSR), .USER_DR_WIDTH(UW)) bus ();

    jtag_tap_multi_dr #(
        .IR_WIDTH(IRW), .NUM_USER_DR(NUSR), .USER_DR_WIDTH(UW),
        .DEVICE_ID(DEVID), .USER_BASE_OPCODE(BASE)
    ) dut (
        .tck(tck), .trst_n(trst_n), .bus(bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic  exp_tdo[$];
    upd_t  exp_upd[$];
    bit    exp_shift = 1'b0;

    int                 m_instr = 1;
    logic [NUSR*UW-1:0] m_upd = '0;
    bit                 m_len_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: tdo is checked against the model whenever the DUT says it is shifting;
    // every strobe must match a queued update event.
    always @(negedge tck) begin
        if (trst_n) begin
            chk("tdo_en", 64'(bus.tdo_en), 64'(exp_shift));
            if (bus.tdo_en) begin
                if (exp_tdo.size() == 0) chk("tdo_unexpected", 64'(bus.tdo_en), 64'd0);
                else chk("tdo", 64'(bus.tdo), 64'(exp_tdo.pop_front()));
            end else begin
                chk("tdo_idle", 64'(bus.tdo), 64'd0);
            end
            if (bus.user_update_strobe != '0) begin
                if (exp_upd.size() == 0) begin
                    chk("strobe_unexpected", 64'(bus.user_update_strobe), 64'd0);
                end else begin
                    upd_t u;
                    u = exp_upd.pop_front();
                    chk("strobe", 64'(bus.user_update_strobe), 64'(1) << u.idx);
                    chk("strobe_data", 64'(bus.user_update_data), 64'(u.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk(input logic m, input logic d);
        bus.tms = m;
        bus.tdi = d;
        @(posedge tck);
        #1;
    endtask

    // -2 IDCODE, -1 BYPASS, k>=0 USERk
    function automatic int kind_of(input int op);
        if (op == 1) return -2;
        if (op == (1 << IRW) - 1) return -1;
        if (op >= BASE && op < BASE + NUSR) return op - BASE;
        return -1;
    endfunction

    task automatic check_static(input string tag);
        chk({tag, "_instr"}, 64'(bus.instruction), 64'(m_instr));
        chk({tag, "_upd"}, 64'(bus.user_update_data), 64'(m_upd));
`ifdef JTAG_DR_LEN_CHECK_EN
        chk({tag, "_len_err"}, 64'(bus.len_err), 64'(m_len_err));
`endif
    endtask

    task automatic ir_scan(input int op);
        logic q[$];
        for (int i = 0; i < IRW; i++) q.push_back(logic'(i == 0));
        clk(1, 0); clk(1, 0); clk(0, 0); clk(0, 0);
        exp_shift = 1'b1;
        for (int i = 0; i < IRW; i++) begin
            logic b;
            b = logic'((op >> i) & 1);
            exp_tdo.push_back(q.pop_front());
            q.push_back(b);
            clk(i == IRW - 1, b);
        end
        exp_shift = 1'b0;
        clk(1, 0); clk(0, 0);
        m_instr = op;
        chk("ir_state", 64'(bus.tap_state), 64'hC);
        check_static("ir");
    endtask

    task automatic tlr_tms();
        for (int i = 0; i < 5; i++) clk(1, logic'($urandom_range(0, 1)));
        m_instr = 1;
        m_len_err = 1'b0;
        chk("tlr_state", 64'(bus.tap_state), 64'hF);
        check_static("tlr");
        clk(0, 0);
    endtask

    // n-bit DR scan from RTI; optional pause after bit pause_at, optional trst at abort_at.
    task automatic dr_scan(input int n, input logic [63:0] data, input int pause_at, input int abort_at);
        logic q[$];
        int   k;
        int   w;
        logic [31:0] cap;
        k = kind_of(m_instr);
        if (k == -2) begin w = 32; cap = DEVID; end
        else if (k == -1) begin w = 1; cap = '0; end
        else begin w = UW; cap = 32'(bus.user_capture_data[k*UW +: UW]); end
        for (int i = 0; i < w; i++) q.push_back(cap[i]);
        clk(1, 0); clk(0, 0); clk(0, 0);
        exp_shift = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic b;
            bit   last, pz;
            if (i == abort_at) begin
                exp_shift = 1'b0;
                #1 trst_n = 1'b0;
                #1;
                m_upd = '0; m_instr = 1; m_len_err = 1'b0;
                chk("abort_state", 64'(bus.tap_state), 64'hF);
                chk("abort_strobe", 64'(bus.user_update_strobe), 64'd0);
                chk("abort_tdo_en", 64'(bus.tdo_en), 64'd0);
                check_static("abort");
                #1 trst_n = 1'b1;
                clk(0, 0);
                return;
            end
            b = data[i];
            last = (i == n - 1);
            pz = (i == pause_at) && !last;
            exp_tdo.push_back(q.pop_front());
            q.push_back(b);
            clk(last || pz, b);
            if (last || pz) exp_shift = 1'b0;
            if (pz) begin
                for (int p = 0; p < 3; p++) clk(0, logic'($urandom_range(0, 1)));
                clk(1, 0); clk(0, 0);
                exp_shift = 1'b1;
            end
        end
        if (k >= 0) begin
`ifdef JTAG_DR_LEN_CHECK_EN
            if (n != UW) m_len_err = 1'b1;
            else
`endif
            begin
                upd_t u;
                for (int j = 0; j < UW; j++) m_upd[k*UW + j] = q[j];
                u.idx = k;
                u.data = m_upd;
                exp_upd.push_back(u);
            end
        end
        clk(1, 0); clk(0, 0);
        chk("dr_state", 64'(bus.tap_state), 64'hC);
        check_static("dr");
    endtask

    initial begin
        bus.tms = 1'b1;
        bus.tdi = 1'b0;
        bus.user_capture_data = {16'h0F0F, 16'h0000};
        repeat (3) @(posedge tck);
        #1;
        chk("rst_state", 64'(bus.tap_state), 64'hF);
        chk("rst_tdo", 64'(bus.tdo), 64'd0);
        chk("rst_tdo_en", 64'(bus.tdo_en), 64'd0);
        chk("rst_strobe", 64'(bus.user_update_strobe), 64'd0);
        check_static("rst");
        #2 trst_n = 1'b1;

        tlr_tms();
        dr_scan(32, {$urandom, $urandom}, -1, -1);

        ir_scan(15);
        dr_scan(5, 64'b01011, -1, -1);

        ir_scan(4);
        bus.user_capture_data[15:0] = 16'hA5C3;
        dr_scan(16, 64'h1234, -1, -1);
        chk("slice0", 64'(bus.user_update_data[15:0]), 64'h1234);
        chk("slice1_held", 64'(bus.user_update_data[31:16]), 64'h0);

        ir_scan(9);
        dr_scan(8, {$urandom, $urandom}, -1, -1);
        ir_scan(5);
        bus.user_capture_data[31:16] = 16'(($urandom));
        dr_scan(16, {$urandom, $urandom}, 6, -1);

        for (int it = 0; it < 24; it++) begin
            int ops[8];
            int op, n;
            ops = '{1, 15, 4, 5, 4, 5, 9, 0};
            op = (it % 5 == 4) ? int'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
            ir_scan(op);
            bus.user_capture_data = {16'($urandom), 16'($urandom)};
            n = ($urandom_range(0, 1) == 1) ? UW : int'($urandom_range(1, 40));
            dr_scan(n, {$urandom, $urandom}, int'($urandom_range(0, 40)), -1);
            if (it % 7 == 6) tlr_tms();
        end

        tlr_tms();
        ir_scan(4);
        dr_scan(16, {$urandom, $urandom}, -1, 7);
        chk("post_abort_state", 64'(bus.tap_state), 64'hC);

`ifdef JTAG_DR_LEN_CHECK_EN
        ir_scan(4);
        dr_scan(16, 64'hBEEF, -1, -1);
        ir_scan(4);
        dr_scan(15, 64'h7123, -1, -1);
        chk("len_err_set", 64'(bus.len_err), 64'd1);
        tlr_tms();
`endif

        repeat (3) clk(0, 0);
        chk("tdo_queue_drained", 64'(exp_tdo.size()), 64'd0);
        chk("upd_queue_drained", 64'(exp_upd.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
